// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end.
// Sequential PC generation, 1-cycle-latency instruction memory reads,
// a small circular FIFO toward decode with valid/ready, and redirect
// handling that flushes queued and in-flight fetches.
// Optional build macro IF_PERF_EN adds saturating perf_fetched and
// perf_flushed counters on the port list.
module if_fetch_queue #(
  parameter int unsigned    PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic [31:0]     im_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_inst,
`ifdef IF_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed,
`endif
  output logic [PC_W-1:0] current_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] OCC_MAX = (PW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_d [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];

  logic [PW-1:0]   count;
  logic [PW:0]     occupancy;
  logic            empty;
  logic            issue;
  logic            push;
  logic            pop;
  logic            resp_kill;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;

  // The low two redirect bits are masked off; this keeps them visibly consumed.
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Occupancy, issue/push/pop decisions. Pops are not credited toward
  // the issue budget so the queue can never overflow.
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    occupancy = {1'b0, count} + {{PW{1'b0}}, inflight_q};
    rd_idx    = rd_ptr_q[AW-1:0];
    wr_idx    = wr_ptr_q[AW-1:0];
    issue     = rst && !redirect_valid && (occupancy < OCC_MAX);
    // A response arriving in a redirect cycle belongs to the old path.
    resp_kill = inflight_q && redirect_valid;
    push      = inflight_q && !redirect_valid;
    pop       = !empty && if_ready && !redirect_valid;
  end

  // Next-state for PC, in-flight tracking, pointers and queue storage.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect_valid) begin
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(4);
        resp_pc_d  = fetch_pc_q;
      end
      if (push) begin
        pc_mem_d[wr_idx]   = resp_pc_q;
        inst_mem_d[wr_idx] = im_rdata;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  // Memory request and decode-side outputs.
  always_comb begin
    im_req     = issue;
    im_addr    = fetch_pc_q;
    if_valid   = !empty;
    if_pc      = empty ? '0 : pc_mem_q[rd_idx];
    if_inst    = empty ? '0 : inst_mem_q[rd_idx];
    current_pc = empty ? fetch_pc_q : pc_mem_q[rd_idx];
  end

`ifdef IF_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flushed_sum;

  // Saturating counters: accepted instructions and entries thrown away.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    flushed_sum    = {1'b0, perf_flushed_q} + 33'(count) + 33'(resp_kill);
    if (pop && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (redirect_valid) begin
      perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  logic unused_kill;
  assign unused_kill = resp_kill;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the fetch front end.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [63:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [63:0] current_pc;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  if_fetch_queue #(.PC_W(64), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
`ifdef IF_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
`endif
    .current_pc     (current_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  // addi x0,x0,imm with the immediate derived from the word address
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return 32'h0000_0013 | {a[13:2], 20'h0};
  endfunction

  // Instruction memory: synchronous read, one cycle latency
  always @(posedge clk) begin
    if (im_req) im_rdata <= inst_of(im_addr);
  end

  // Reference model
  logic [63:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic [63:0] m_fpc;
  bit          m_infl;
  logic [63:0] m_infl_pc;
  longint      m_fetched;
  longint      m_flushed;

  task automatic model_reset();
    m_pc.delete();
    m_inst.delete();
    m_fpc = 64'h0;
    m_infl = 0;
    m_infl_pc = 64'h0;
    m_fetched = 0;
    m_flushed = 0;
  endtask

  function automatic bit m_req();
    return rst && !redirect_valid && ((m_pc.size() + int'(m_infl)) < DEPTH);
  endfunction

  function automatic logic [225:0] exp_vec();
    bit hv;
    hv = (m_pc.size() > 0);
    return {m_req(), m_fpc, hv, hv ? m_pc[0] : 64'h0, hv ? m_inst[0] : 32'h0,
            hv ? m_pc[0] : m_fpc};
  endfunction

  function automatic logic [225:0] obs_vec();
    return {im_req, im_addr, if_valid, if_pc, if_inst, current_pc};
  endfunction

  // Apply inputs mid-cycle, leaving time for combinational outputs to settle
  task automatic drive(input bit rdy, input bit rv, input logic [63:0] rp);
    @(negedge clk);
    if_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rp;
    #1;
  endtask

  // Advance one clock and step the model with the inputs seen at the edge
  task automatic advance();
    bit req;
    @(posedge clk);
    req = m_req();
    if (redirect_valid) begin
      m_flushed += m_pc.size() + int'(m_infl);
      m_pc.delete();
      m_inst.delete();
      m_fpc = {redirect_pc[63:2], 2'b00};
      m_infl = 0;
    end else begin
      if (m_pc.size() > 0 && if_ready) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
        m_fetched++;
      end
      if (m_infl) begin
        m_pc.push_back(m_infl_pc);
        m_inst.push_back(inst_of(m_infl_pc));
      end
      if (req) begin
        m_infl = 1;
        m_infl_pc = m_fpc;
        m_fpc = m_fpc + 64'd4;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    if_ready = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    model_reset();
    #12;
    checks++;
    if ({im_req, if_valid, if_pc, if_inst, current_pc} !== 162'h0)
      $display("FAIL reset_outputs got req=%b v=%b pc=%h inst=%h cur=%h want all zero",
               im_req, if_valid, if_pc, if_inst, current_pc);
    else passed++;
  endtask

  task automatic test_steady();
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 64'h0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL steady cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 64'h0);
      if (im_req) reqs++;
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stall cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
    checks++;
    if (reqs !== DEPTH) $display("FAIL stall_req_count got %0d want %0d", reqs, DEPTH);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 64'h0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stall_release cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
  endtask

  task automatic test_redirect_full();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 64'h0);
      advance();
    end
    drive(0, 1, 64'h100);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL redir_full_cycle got %h want %h", obs_vec(), exp_vec());
    else passed++;
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 64'h0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL redir_full cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      if (if_valid) begin
        checks++;
        if (if_pc < 64'h100) $display("FAIL redir_stale got pc %h want >= 100", if_pc);
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_redirect_kill();
    bit seen;
    seen = 0;
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 64'h0);
      advance();
    end
    drive(1, 1, 64'h42);
    advance();
    for (int c = 0; c < 8 && !seen; c++) begin
      drive(1, 0, 64'h0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL redir_kill cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      if (if_valid) begin
        seen = 1;
        checks++;
        if (if_pc !== 64'h40) $display("FAIL redir_kill_first_pc got %h want 40", if_pc);
        else passed++;
      end
      advance();
    end
    if (!seen) begin
      checks++;
      $display("FAIL redir_kill_timeout got no if_valid want if_pc 40");
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 64'h0);
      advance();
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({im_req, if_valid, if_pc, if_inst, current_pc} !== 162'h0)
      $display("FAIL async_reset got req=%b v=%b pc=%h cur=%h want all zero",
               im_req, if_valid, if_pc, current_pc);
    else passed++;
    rst = 1'b1;
    model_reset();
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 64'h0);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL async_resume cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
  endtask

  task automatic test_random();
    bit rdy, rv;
    logic [63:0] rp;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else rp = {32'($urandom), 32'($urandom)};
      drive(rdy, rv, rp);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random cyc%0d got %h want %h", c, obs_vec(), exp_vec());
      else passed++;
      advance();
    end
`ifdef IF_PERF_EN
    drive(0, 0, 64'h0);
    checks++;
    if (perf_fetched !== 32'(m_fetched) || perf_flushed !== 32'(m_flushed))
      $display("FAIL random_perf got %0d/%0d want %0d/%0d", perf_fetched, perf_flushed,
               m_fetched, m_flushed);
    else passed++;
`endif
  endtask

`ifdef IF_PERF_EN
  task automatic test_perf();
    int c;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 64'h0);
      advance();
    end
    drive(0, 1, 64'h200);
    advance();
    drive(0, 0, 64'h0);
    checks++;
    if (perf_flushed !== 32'd4) $display("FAIL perf_flushed got %0d want 4", perf_flushed);
    else passed++;
    c = 0;
    while (m_fetched < 20 && c < 80) begin
      drive(1, 0, 64'h0);
      advance();
      c++;
    end
    drive(0, 0, 64'h0);
    checks++;
    if (perf_fetched !== 32'd20 || m_fetched != 20)
      $display("FAIL perf_fetched got %0d want 20", perf_fetched);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_steady();
    test_stall();
    test_redirect_full();
    test_redirect_kill();
    test_async_reset();
`ifdef IF_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end of the RV64I core.
- Generates sequential PCs and issues reads to the instruction memory (`im`, synchronous read, 1-cycle latency).
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing buffered and in-flight fetches; `current_pc` is driven from this block's output.

Parameters:
- RESET_PC, 64'h0, PC of the first fetch after reset.
- DEPTH, 4, instruction queue entries (power of two, ≥2).
- PC_W, 64, PC width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- im_req  out  1  read strobe to instruction memory
- im_addr  out  PC_W  byte address of read; bits [1:0] always 0
- im_rdata  in  32  instruction word, valid the cycle after im_req
- redirect_valid  in  1  execute requests PC change (taken branch/jal/jalr)
- redirect_pc  in  PC_W  redirect target
- if_valid  out  1  queue head holds a valid instruction
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  PC_W  PC of head instruction
- if_inst  out  32  head instruction word
- current_pc  out  PC_W  PC of head if if_valid, else the next fetch PC

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, queue empty, inflight=0.
  - Outputs: im_req=0, if_valid=0, if_pc=0, if_inst=0, current_pc=RESET_PC.
- Issue rule (combinational im_req): im_req=1 when rst=1, redirect_valid=0, and count+inflight < DEPTH.
  - Pops in the same cycle are not credited.
  - im_addr=fetch_pc; on issue fetch_pc += 4, inflight <= 1.
- Response:
  - The cycle after an issue, im_rdata is pushed with its PC (captured at issue) unless the kill flag is set.
  - Push can never overflow, guaranteed by the issue rule.
- Queue: circular FIFO, DEPTH entries, pointers of log2(DEPTH)+1 bits.
  - count = wr_ptr - rd_ptr.
  - Full when count==DEPTH; empty when count==0.
  - if_valid = !empty; if_pc/if_inst = head entry, 0 when empty.
- Pop when if_valid && if_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - if_ready while empty has no effect.
- Redirect (redirect_valid=1 at edge):
  - Queue cleared (rd_ptr<=wr_ptr).
  - Any in-flight response is killed (kill<=inflight); it is discarded next cycle, not pushed.
  - fetch_pc <= {redirect_pc[PC_W-1:2],2'b00}.
  - No issue in the redirect cycle; first issue from the new PC is the following cycle.
  - A pop in the same cycle as a redirect is ignored.
- Back-to-back redirects: the last one wins; each kills any in-flight response.
- Address arithmetic: fetch_pc wraps modulo 2^PC_W; no exception on wrap.
- Steady state with if_ready=1: one instruction per cycle after a 2-cycle start latency.
  - Reset release → first im_req same cycle → if_valid next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight data is discarded.

Optional Feature:
- Macro: IF_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (increments on each pop) and perf_flushed[31:0] (increments by entries discarded on redirect: count plus 1 if a response is killed).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, if_ready=1, im returns `addi` words → im_addr 0x0,0x4,0x8…; if_pc 0x0 appears 1 cycle after first im_req, then one per cycle.
- if_ready=0 for 10 cycles → exactly DEPTH=4 requests issued (0x0–0xC); im_req held 0; if_valid=1, if_pc=0x0 stable; release → pops in order 0x0,0x4,0x8,0xC, then fetch resumes at 0x10.
- Full queue, redirect_valid with redirect_pc=0x100 → next cycle if_valid=0; im_addr=0x100 issued the cycle after; no old PCs ever reach decode.
- Redirect in the cycle after an issue to 0x8 → killed response not pushed; first if_pc=0x40 for redirect_pc=0x42 (low bits masked).
- Async rst pulse between clock edges mid-stream → outputs reset immediately; next fetch at RESET_PC; current_pc=0x0.
- IF_PERF_EN defined: redirect with 3 queued + 1 in flight → perf_flushed=4; 20 pops → perf_fetched=20.
